unidade_controle_multiciclo: RTL and testbench

//  Control unit sequencing the 16-bit multicycle processor datapath (R0-R7, A, G, ALU, shared bus).

---
 rtl/unidade_controle_multiciclo.sv | 149 ++++++++++++++
 tb/tb_unidade_controle_multiciclo.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/unidade_controle_multiciclo.sv
// Control unit for the 16-bit multicycle processor datapath.
// Latches a 9-bit instruction {opcode, Rx, Ry} from DIN in T0, then walks
// T1..T3 driving one-hot register enables, bus-source selects, ALU op and Done.
// Optional retired-instruction counter: define INSTR_COUNT_EN to build it;
// otherwise InstrCount is tied to zero and no counter flops exist.
module unidade_controle_multiciclo #(
  parameter int DATA_WIDTH = 16,
  parameter int IR_WIDTH   = 9,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Run,
  input  logic [DATA_WIDTH-1:0] DIN,
  output logic [IR_WIDTH-1:0]   IR,
  output logic [2:0]            Tstep,
  output logic                  IRin,
  output logic [7:0]            Rin,
  output logic [7:0]            Rout,
  output logic                  DINout,
  output logic                  Gout,
  output logic                  Ain,
  output logic                  Gin,
  output logic [2:0]            ALUop,
  output logic                  Done,
  output logic [CNT_WIDTH-1:0]  InstrCount
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } tstep_e;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;

  tstep_e              tstep_q, tstep_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;

  logic [2:0] opcode;
  logic [2:0] rx;
  logic [2:0] ry;

  // Upper DIN bits carry no instruction information at fetch.
  logic unused_din;
  assign unused_din = ^DIN[DATA_WIDTH-1:IR_WIDTH];

  assign opcode = ir_q[8:6];
  assign rx     = ir_q[5:3];
  assign ry     = ir_q[2:0];

  assign IR    = ir_q;
  assign Tstep = {1'b0, tstep_q};

  // Decode a 3-bit register index into a one-hot enable.
  function automatic logic [7:0] reg_sel(input logic [2:0] idx);
    reg_sel = 8'b0000_0001 << idx;
  endfunction

  // Next-step and control decode; Reset forces every control output low.
  always_comb begin
    tstep_d = tstep_q;
    ir_d    = ir_q;
    IRin    = 1'b0;
    Rin     = 8'h00;
    Rout    = 8'h00;
    DINout  = 1'b0;
    Gout    = 1'b0;
    Ain     = 1'b0;
    Gin     = 1'b0;
    ALUop   = 3'b000;
    Done    = 1'b0;
    if (!Reset) begin
      unique case (tstep_q)
        T0: begin
          IRin = Run;
          if (Run) begin
            ir_d    = DIN[IR_WIDTH-1:0];
            tstep_d = T1;
          end
        end
        T1: begin
          if (opcode == OP_MV) begin
            Rout    = reg_sel(ry);
            Rin     = reg_sel(rx);
            Done    = 1'b1;
            tstep_d = T0;
          end else if (opcode == OP_MVI) begin
            DINout  = 1'b1;
            Rin     = reg_sel(rx);
            Done    = 1'b1;
            tstep_d = T0;
          end else begin
            Rout    = reg_sel(rx);
            Ain     = 1'b1;
            tstep_d = T2;
          end
        end
        T2: begin
          Rout    = reg_sel(ry);
          Gin     = 1'b1;
          ALUop   = opcode;
          tstep_d = T3;
        end
        T3: begin
          Gout    = 1'b1;
          Rin     = reg_sel(rx);
          Done    = 1'b1;
          tstep_d = T0;
        end
        default: tstep_d = T0;
      endcase
    end
  end

  // Step counter and instruction register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      tstep_q <= T0;
      ir_q    <= '0;
    end else begin
      tstep_q <= tstep_d;
      ir_q    <= ir_d;
    end
  end

`ifdef INSTR_COUNT_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Retired-instruction count; wraps silently.
  always_comb begin
    cnt_d = cnt_q;
    if (Done) cnt_d = cnt_q + 1'b1;
  end

  // Counter register, cleared by Reset.
  always_ff @(posedge Clock) begin
    if (Reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign InstrCount = cnt_q;
`else
  assign InstrCount = '0;
`endif

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Directed bench for unidade_controle_multiciclo with an expected-output queue.
module tb_unidade_controle_multiciclo;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Run;
  logic [15:0] DIN;
  logic [8:0]  IR;
  logic [2:0]  Tstep;
  logic        IRin;
  logic [7:0]  Rin;
  logic [7:0]  Rout;
  logic        DINout;
  logic        Gout;
  logic        Ain;
  logic        Gin;
  logic [2:0]  ALUop;
  logic        Done;
  logic [15:0] InstrCount;

  logic [36:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt = 16'd0;

  always #5 Clock = ~Clock;

  unidade_controle_multiciclo dut (
    .Clock(Clock), .Reset(Reset), .Run(Run), .DIN(DIN), .IR(IR), .Tstep(Tstep),
    .IRin(IRin), .Rin(Rin), .Rout(Rout), .DINout(DINout), .Gout(Gout),
    .Ain(Ain), .Gin(Gin), .ALUop(ALUop), .Done(Done), .InstrCount(InstrCount)
  );

  function automatic logic [36:0] ev(input logic [2:0] t, input logic [8:0] ir,
                                     input logic irin, input logic [7:0] rin,
                                     input logic [7:0] rout, input logic dinout,
                                     input logic gout, input logic ain, input logic gin,
                                     input logic [2:0] alu, input logic done);
    ev = {t, ir, irin, rin, rout, dinout, gout, ain, gin, alu, done};
  endfunction

  // Drive one cycle of inputs, queue the expected outputs, then compare.
  task automatic cyc(input string tag, input logic rst, input logic run,
                     input logic [15:0] din, input logic [36:0] e);
    logic [36:0] obs;
    logic [36:0] exp_v;
    @(negedge Clock);
    Reset = rst;
    Run   = run;
    DIN   = din;
    exp_q.push_back(e);
    #1;
    obs   = {Tstep, IR, IRin, Rin, Rout, DINout, Gout, Ain, Gin, ALUop, Done};
    exp_v = exp_q.pop_front();
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
    checks++;
    assert (InstrCount === exp_cnt) else begin
      errors++;
      $error("FAIL %s_cnt: observed %0d expected %0d", tag, InstrCount, exp_cnt);
    end
    checks++;
    assert ($countones({Rout, DINout, Gout}) <= 1 && $countones(Rin) <= 1) else begin
      errors++;
      $error("FAIL %s_bus: observed Rout=%h DINout=%b Gout=%b Rin=%h expected at most one source",
             tag, Rout, DINout, Gout, Rin);
    end
`ifdef INSTR_COUNT_EN
    if (rst) exp_cnt = 16'd0;
    else if (e[0]) exp_cnt = exp_cnt + 16'd1;
`endif
  endtask

  initial begin
    Reset = 1'b1;
    Run   = 1'b0;
    DIN   = 16'h0000;

    // Reset for two cycles, including Run=1 with a busy DIN.
    cyc("rst0", 1'b1, 1'b1, 16'h01FF, ev(3'd0, 9'h000, 0, 8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 0));
    cyc("rst1", 1'b1, 1'b0, 16'h0000, ev(3'd0, 9'h000, 0, 8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 0));
    for (int i = 0; i < 5; i++)
      cyc("idle", 1'b0, 1'b0, 16'h0155, ev(3'd0, 9'h000, 0, 8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 0));

    // mvi R0, #5
    cyc("mvi_t0", 1'b0, 1'b1, 16'h0040, ev(3'd0, 9'h000, 1, 8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 0));
    cyc("mvi_t1", 1'b0, 1'b0, 16'h0005, ev(3'd1, 9'h040, 0, 8'h01, 8'h00, 1, 0, 0, 0, 3'b000, 1));
    cyc("mvi_end", 1'b0, 1'b0, 16'h0000, ev(3'd0, 9'h040, 0, 8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 0));

    // mv R1, R0
    cyc("mv_t0", 1'b0, 1'b1, 16'h0008, ev(3'd0, 9'h040, 1, 8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 0));
    cyc("mv_t1", 1'b0, 1'b0, 16'h0000, ev(3'd1, 9'h008, 0, 8'h02, 8'h01, 0, 0, 0, 0, 3'b000, 1));

    // add R1, R0 with junk in DIN[15:9]; Run held high during execution is ignored
    cyc("add_t0", 1'b0, 1'b1, 16'hFE88, ev(3'd0, 9'h008, 1, 8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 0));
    cyc("add_t1", 1'b0, 1'b1, 16'h01FF, ev(3'd1, 9'h088, 0, 8'h00, 8'h02, 0, 0, 1, 0, 3'b000, 0));
    cyc("add_t2", 1'b0, 1'b0, 16'h0000, ev(3'd2, 9'h088, 0, 8'h00, 8'h01, 0, 0, 0, 1, 3'b010, 0));
    cyc("add_t3", 1'b0, 1'b0, 16'h0000, ev(3'd3, 9'h088, 0, 8'h02, 8'h00, 0, 1, 0, 0, 3'b000, 1));
    cyc("add_end", 1'b0, 1'b0, 16'h0000, ev(3'd0, 9'h088, 0, 8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 0));

    // sll R3, R3 (Rx == Ry, top opcode)
    cyc("sll_t0", 1'b0, 1'b1, 16'h01DB, ev(3'd0, 9'h088, 1, 8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 0));
    cyc("sll_t1", 1'b0, 1'b0, 16'h0000, ev(3'd1, 9'h1DB, 0, 8'h00, 8'h08, 0, 0, 1, 0, 3'b000, 0));
    cyc("sll_t2", 1'b0, 1'b0, 16'h0000, ev(3'd2, 9'h1DB, 0, 8'h00, 8'h08, 0, 0, 0, 1, 3'b111, 0));
    cyc("sll_t3", 1'b0, 1'b0, 16'h0000, ev(3'd3, 9'h1DB, 0, 8'h08, 8'h00, 0, 1, 0, 0, 3'b000, 1));

    // sub R2, R3 abandoned by Reset in T2
    cyc("sub_t0", 1'b0, 1'b1, 16'h00D3, ev(3'd0, 9'h1DB, 1, 8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 0));
    cyc("sub_t1", 1'b0, 1'b0, 16'h0000, ev(3'd1, 9'h0D3, 0, 8'h00, 8'h04, 0, 0, 1, 0, 3'b000, 0));
    cyc("sub_t2rst", 1'b1, 1'b0, 16'h0000, ev(3'd2, 9'h0D3, 0, 8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 0));
    cyc("sub_after", 1'b0, 1'b0, 16'h0000, ev(3'd0, 9'h000, 0, 8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 0));
    cyc("sub_idle", 1'b0, 1'b0, 16'h0000, ev(3'd0, 9'h000, 0, 8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 0));

    // Back-to-back mvi, mv, add with Run held high after a fresh reset
    cyc("b2b_rst", 1'b1, 1'b1, 16'h0040, ev(3'd0, 9'h000, 0, 8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 0));
    cyc("b2b_mvi0", 1'b0, 1'b1, 16'h0040, ev(3'd0, 9'h000, 1, 8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 0));
    cyc("b2b_mvi1", 1'b0, 1'b1, 16'h0005, ev(3'd1, 9'h040, 0, 8'h01, 8'h00, 1, 0, 0, 0, 3'b000, 1));
    cyc("b2b_mv0", 1'b0, 1'b1, 16'h0008, ev(3'd0, 9'h040, 1, 8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 0));
    cyc("b2b_mv1", 1'b0, 1'b1, 16'h0000, ev(3'd1, 9'h008, 0, 8'h02, 8'h01, 0, 0, 0, 0, 3'b000, 1));
    cyc("b2b_add0", 1'b0, 1'b1, 16'h0088, ev(3'd0, 9'h008, 1, 8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 0));
    cyc("b2b_add1", 1'b0, 1'b1, 16'h0000, ev(3'd1, 9'h088, 0, 8'h00, 8'h02, 0, 0, 1, 0, 3'b000, 0));
    cyc("b2b_add2", 1'b0, 1'b1, 16'h0000, ev(3'd2, 9'h088, 0, 8'h00, 8'h01, 0, 0, 0, 1, 3'b010, 0));
    cyc("b2b_add3", 1'b0, 1'b1, 16'h0000, ev(3'd3, 9'h088, 0, 8'h02, 8'h00, 0, 1, 0, 0, 3'b000, 1));
    cyc("b2b_end", 1'b0, 1'b0, 16'h0000, ev(3'd0, 9'h088, 0, 8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 0));

    // Final retired-instruction count after the back-to-back run
    checks++;
`ifdef INSTR_COUNT_EN
    assert (InstrCount === 16'd3) else begin
      errors++;
      $error("FAIL final_cnt: observed %0d expected 3", InstrCount);
    end
`else
    assert (InstrCount === 16'd0) else begin
      errors++;
      $error("FAIL final_cnt: observed %0d expected 0", InstrCount);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
